// File: rtl/keypad_pkg.sv
// Shared types, keymap and scan classification for the 4x4 keypad scanner.
// Auto-repeat (KEYPAD_REPEAT_EN) is handled in keypad_debounce.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_class_t;

  typedef struct packed {
    scan_class_t cls;
    logic [3:0]  idx;
  } scan_res_t;

  // Indexed by {row, col}; column 0 is the leftmost key of a row.
  localparam key_code_t KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic scan_res_t classify_scan(input logic [15:0] lows);
    scan_res_t  res;
    logic [4:0] n;
    logic [3:0] idx;
    n   = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (lows[i]) begin
        n   = n + 5'd1;
        idx = i[3:0];
      end
    end
    res.idx = idx;
    if (n == 5'd0)      res.cls = NONE;
    else if (n == 5'd1) res.cls = SINGLE;
    else                res.cls = MULTI;
    return res;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM and one-deep valid/ack key buffer for the keypad scanner.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_SCANS scans.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_done,
  input  scan_class_t scan_class,
  input  key_code_t   scan_code,
  input  logic        key_ack,
  output key_code_t   key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic        overflow
);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be in 1..15");
  end
  if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_repeat
    $error("REPEAT_SCANS must be in 1..255");
  end

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  deb_state_t state_reg, state_next;
  logic [3:0] count_reg, count_next;
  key_code_t  cand_reg, cand_next;
  logic       emit;
  key_code_t  emit_code;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_SCANS);
  logic [7:0] rep_reg, rep_next;
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    cand_next  = cand_reg;
    emit       = 1'b0;
    emit_code  = cand_reg;
`ifdef KEYPAD_REPEAT_EN
    rep_next   = rep_reg;
`endif
    if (scan_done) begin
      case (state_reg)
        IDLE: begin
          if (scan_class == SINGLE) begin
            cand_next  = scan_code;
            count_next = 4'd1;
            emit_code  = scan_code;
            if (DEB_LAST == 4'd1) begin
              state_next = HELD;
              emit       = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_next   = '0;
`endif
            end else begin
              state_next = PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (scan_class == SINGLE) begin
            if (scan_code == cand_reg) begin
              count_next = count_reg + 4'd1;
              if (count_reg + 4'd1 == DEB_LAST) begin
                state_next = HELD;
                emit       = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_next   = '0;
`endif
              end
            end else begin
              cand_next  = scan_code;
              count_next = 4'd1;
            end
          end else begin
            state_next = IDLE;
          end
        end
        HELD: begin
          if (scan_class == NONE) begin
            count_next = 4'd1;
            state_next = (DEB_LAST == 4'd1) ? IDLE : RELEASE_WAIT;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_reg + 8'd1 == REP_LAST) begin
              emit     = 1'b1;
              rep_next = '0;
            end else begin
              rep_next = rep_reg + 8'd1;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (scan_class == NONE) begin
            count_next = count_reg + 4'd1;
            if (count_reg + 4'd1 == DEB_LAST) state_next = IDLE;
          end else begin
            // Repeat counter is left frozen so a bounce resumes the cadence.
            state_next = HELD;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      cand_reg  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      cand_reg  <= cand_next;
`ifdef KEYPAD_REPEAT_EN
      rep_reg   <= rep_next;
`endif
      if (emit) begin
        if (!key_valid || key_ack) begin
          key_code  <= emit_code;
          key_valid <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

  assign key_held = (state_reg == HELD) || (state_reg == RELEASE_WAIT);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row strobe, column synchronizer and scan classification.
// KEYPAD_REPEAT_EN enables auto-repeat of a held key in keypad_debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overflow
);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be >= 4");
  end

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] dwell_reg;
  logic [1:0]    row_idx_reg;
  logic [3:0]    col_meta_reg, col_sync_reg;
  logic [3:0]    lows_reg [3];
  logic          scan_done_reg;
  scan_class_t   scan_class_reg;
  key_code_t     scan_code_reg;
  logic          last_dwell;
  scan_res_t     scan_res;

  assign last_dwell = (dwell_reg == DWELL_LAST);
  // Row 3 is classified straight from the synchronizer on its sample cycle.
  assign scan_res = classify_scan({~col_sync_reg, lows_reg[2], lows_reg[1], lows_reg[0]});

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row[gi] = (row_idx_reg != 2'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_reg   <= 4'b1111;
      col_sync_reg   <= 4'b1111;
      dwell_reg      <= '0;
      row_idx_reg    <= '0;
      scan_done_reg  <= 1'b0;
      scan_class_reg <= NONE;
      scan_code_reg  <= '0;
      for (int i = 0; i < 3; i++) lows_reg[i] <= '0;
    end else begin
      col_meta_reg  <= col;
      col_sync_reg  <= col_meta_reg;
      scan_done_reg <= 1'b0;
      if (last_dwell) begin
        dwell_reg   <= '0;
        row_idx_reg <= row_idx_reg + 2'd1;
        for (int i = 0; i < 3; i++) begin
          if (row_idx_reg == 2'(i)) lows_reg[i] <= ~col_sync_reg;
        end
        if (row_idx_reg == 2'd3) begin
          scan_done_reg  <= 1'b1;
          scan_class_reg <= scan_res.cls;
          scan_code_reg  <= KEYMAP[scan_res.idx];
        end
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_SCANS  (REPEAT_SCANS)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .scan_done (scan_done_reg),
    .scan_class(scan_class_reg),
    .scan_code (scan_code_reg),
    .key_ack   (key_ack),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held, overflow;
  logic        key_ack = 1'b0;
  logic [15:0] key_mask = '0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_held (key_held),
    .overflow (overflow)
  );

  // A pressed key shorts its row to its column.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && key_mask[r*4+c]) col[c] = 1'b0;
  end

  typedef struct {
    logic [3:0] code;
    int         t;
  } obs_t;

  obs_t       obs_q[$];
  logic [3:0] exp_q[$];
  int         exp_t_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         edge_cnt = 0;
  int         start_edge = 0;
  logic       valid_prev = 1'b0;
  bit         auto_ack = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] m;
    m = '0;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid && !valid_prev)
        obs_q.push_back('{code: key_code, t: edge_cnt - start_edge});
      valid_prev = key_valid;
      key_ack = auto_ack && key_valid;
    end
  endtask

  task automatic do_reset(input logic [15:0] mask);
    key_mask = mask;
    key_ack  = 1'b0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    reset      = 1'b1;
    start_edge = edge_cnt;
    valid_prev = 1'b0;
    obs_q.delete();
    exp_q.delete();
    exp_t_q.delete();
  endtask

  task automatic test_reset();
    key_mask = key_bit(1, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (row !== 4'b1110) begin tests_failed++; $display("FAIL reset_row: got %b expected 1110", row); end
    tests_run++;
    if (key_code !== 4'h0) begin tests_failed++; $display("FAIL reset_code: got %h expected 0", key_code); end
    tests_run++;
    if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    tests_run++;
    if (key_held !== 1'b0) begin tests_failed++; $display("FAIL reset_held: got %b expected 0", key_held); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    $display("[TB] reset state checked");
  endtask

  task automatic test_single_press();
    obs_t o; logic [3:0] e; int et;
    do_reset(key_bit(1, 2));
    auto_ack = 1'b0;
    exp_q.push_back(4'h6); exp_t_q.push_back(DEB * SCAN + 1);
    step(6 * SCAN);
    tests_run++;
    if (key_held !== 1'b1) begin tests_failed++; $display("FAIL single_held: got %b expected 1", key_held); end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL single_count: got %0d emits expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); et = exp_t_q.pop_front();
      $display("[TB] single emit key=%h at clock %0d", o.code, o.t);
      tests_run++;
      if (o.code !== e || o.t !== et) begin tests_failed++; $display("FAIL single_emit: got key=%h t=%0d expected key=%h t=%0d", o.code, o.t, e, et); end
    end
    key_ack = 1'b1;
    step(1);
    tests_run++;
    if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL single_ack: got valid=%b expected 0", key_valid); end
    key_mask = '0;
  endtask

  task automatic test_bounce();
    obs_t o; logic [3:0] e; int et;
    do_reset('0);
    auto_ack = 1'b1;
    for (int s = 0; s < 8; s++) begin
      key_mask = (s % 2 == 0) ? key_bit(0, 3) : 16'h0000;
      step(SCAN);
    end
    tests_run++;
    if (obs_q.size() !== 0) begin tests_failed++; $display("FAIL bounce_quiet: got %0d emits expected 0", obs_q.size()); end
    key_mask = key_bit(0, 3);
    exp_q.push_back(4'hA); exp_t_q.push_back(11 * SCAN + 1);
    step(5 * SCAN);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL bounce_count: got %0d emits expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); et = exp_t_q.pop_front();
      $display("[TB] bounce emit key=%h at clock %0d", o.code, o.t);
      tests_run++;
      if (o.code !== e || o.t !== et) begin tests_failed++; $display("FAIL bounce_emit: got key=%h t=%0d expected key=%h t=%0d", o.code, o.t, e, et); end
    end
    auto_ack = 1'b0;
    key_mask = '0;
  endtask

  task automatic test_multi_key();
    do_reset(key_bit(0, 0) | key_bit(3, 3));
    auto_ack = 1'b1;
    step(5 * SCAN);
    tests_run++;
    if (key_held !== 1'b0) begin tests_failed++; $display("FAIL multi_held_mid: got %b expected 0", key_held); end
    step(5 * SCAN);
    tests_run++;
    if (key_held !== 1'b0) begin tests_failed++; $display("FAIL multi_held_end: got %b expected 0", key_held); end
    tests_run++;
    if (obs_q.size() !== 0) begin tests_failed++; $display("FAIL multi_count: got %0d emits expected 0", obs_q.size()); end
    $display("[TB] two-key press ignored, emits=%0d", obs_q.size());
    auto_ack = 1'b0;
    key_mask = '0;
  endtask

  task automatic test_overflow();
    obs_t o; logic [3:0] e; int et;
    do_reset(key_bit(1, 1));
    auto_ack = 1'b0;
    exp_q.push_back(4'h5); exp_t_q.push_back(DEB * SCAN + 1);
    step(4 * SCAN);
    key_mask = '0;
    step(4 * SCAN);
    key_mask = key_bit(2, 2);
    step(4 * SCAN);
    tests_run++;
    if (key_code !== 4'h5) begin tests_failed++; $display("FAIL ovf_code: got %h expected 5", key_code); end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL ovf_count: got %0d emits expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); et = exp_t_q.pop_front();
      $display("[TB] overflow emit key=%h at clock %0d", o.code, o.t);
      tests_run++;
      if (o.code !== e || o.t !== et) begin tests_failed++; $display("FAIL ovf_emit: got key=%h t=%0d expected key=%h t=%0d", o.code, o.t, e, et); end
    end
    key_ack = 1'b1;
    step(1);
    tests_run++;
    if (key_valid !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_ack: got valid=%b overflow=%b expected 0 0", key_valid, overflow); end
    key_mask = '0;
  endtask

  task automatic test_release_reset();
    obs_t o; logic [3:0] e; int et;
    do_reset(key_bit(3, 0));
    auto_ack = 1'b1;
    exp_q.push_back(4'h0); exp_t_q.push_back(DEB * SCAN + 1);
    step(4 * SCAN);
    key_mask = '0;
    step(3 * SCAN);
    tests_run++;
    if (key_held !== 1'b1) begin tests_failed++; $display("FAIL release_held_before: got %b expected 1", key_held); end
    step(1);
    tests_run++;
    if (key_held !== 1'b0) begin tests_failed++; $display("FAIL release_held_after: got %b expected 0", key_held); end
    step(SCAN - 1);
    auto_ack = 1'b0;
    key_mask = key_bit(3, 2);
    exp_q.push_back(4'hE); exp_t_q.push_back(11 * SCAN + 1);
    step(4 * SCAN);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL release_count: got %0d emits expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); et = exp_t_q.pop_front();
      $display("[TB] release emit key=%h at clock %0d", o.code, o.t);
      tests_run++;
      if (o.code !== e || o.t !== et) begin tests_failed++; $display("FAIL release_emit: got key=%h t=%0d expected key=%h t=%0d", o.code, o.t, e, et); end
    end
    tests_run++;
    if (key_valid !== 1'b1 || key_held !== 1'b1) begin tests_failed++; $display("FAIL pre_reset: got valid=%b held=%b expected 1 1", key_valid, key_held); end
    step(2 * SCAN_DIV + 1);
    tests_run++;
    if (row !== 4'b1011) begin tests_failed++; $display("FAIL mid_row2: got %b expected 1011", row); end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (row !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got row=%b valid=%b held=%b code=%h ovf=%b expected 1110 0 0 0 0", row, key_valid, key_held, key_code, overflow);
    end
    $display("[TB] asynchronous reset applied mid-dwell");
    @(negedge clk);
    reset      = 1'b1;
    start_edge = edge_cnt;
    valid_prev = 1'b0;
    auto_ack   = 1'b1;
    exp_q.push_back(4'hE); exp_t_q.push_back(DEB * SCAN + 1);
    step(4 * SCAN);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL requal_count: got %0d emits expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); et = exp_t_q.pop_front();
      $display("[TB] requalify emit key=%h at clock %0d", o.code, o.t);
      tests_run++;
      if (o.code !== e || o.t !== et) begin tests_failed++; $display("FAIL requal_emit: got key=%h t=%0d expected key=%h t=%0d", o.code, o.t, e, et); end
    end
    auto_ack = 1'b0;
    key_mask = '0;
  endtask

  task automatic test_repeat();
    obs_t o; logic [3:0] e; int et;
    do_reset(key_bit(3, 1));
    auto_ack = 1'b1;
    exp_q.push_back(4'hF); exp_t_q.push_back(DEB * SCAN + 1);
`ifdef KEYPAD_REPEAT_EN
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(4'hF); exp_t_q.push_back((DEB + k * REP) * SCAN + 1);
    end
`endif
    step(20 * SCAN);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL repeat_count: got %0d emits expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); et = exp_t_q.pop_front();
      $display("[TB] repeat emit key=%h at clock %0d", o.code, o.t);
      tests_run++;
      if (o.code !== e || o.t !== et) begin tests_failed++; $display("FAIL repeat_emit: got key=%h t=%0d expected key=%h t=%0d", o.code, o.t, e, et); end
    end
    tests_run++;
    if (key_held !== 1'b1) begin tests_failed++; $display("FAIL repeat_held: got %b expected 1", key_held); end
    auto_ack = 1'b0;
    key_mask = '0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_overflow();
    test_release_reset();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
